// File: rtl/cla_pipe_adder_if.sv
// cla_pipe_adder_if
//   Operand/result channel of the pipelined CLA adder/subtractor.
//   Input side : in_valid, in_ready, a, b, cin, sub
//   Output side: out_valid, out_ready, sum, cout, ovf
//   master = producer of operands / consumer of results (e.g. a bench or MAC)
//   slave  = the adder itself
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder
//   Pipelined carry-lookahead adder/subtractor. WIDTH bits are split into
//   NGRP = WIDTH/BLOCK lookahead groups; stage k resolves group k, so the
//   latency is NGRP cycles and throughput is one result per cycle.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset (flushes every in-flight result)
//     bus  - cla_pipe_adder_if.slave: valid/ready operand input (a, b, cin,
//            sub) and valid/ready result output (sum, cout, ovf)
//   sub=1 computes a - b - cin; cout is then NOT-borrow. ovf is signed
//   overflow. The whole pipe advances together when the output is empty
//   or being popped.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic            clk,
    input  logic            rst,
    cla_pipe_adder_if.slave bus
);
    localparam int NGRP = WIDTH / BLOCK;

    if (WIDTH % BLOCK != 0) begin : g_width_check
        $error("cla_pipe_adder: WIDTH (%0d) must be a multiple of BLOCK (%0d)", WIDTH, BLOCK);
    end

    // One BLOCK-bit lookahead group. Each carry is a flat sum of products of
    // g/p terms and the group carry-in, so nothing ripples inside the group.
    // Returns {carry into group MSB, group carry-out, group sum}.
    function automatic logic [BLOCK+1:0] cla_group(input logic [BLOCK-1:0] x,
                                                   input logic [BLOCK-1:0] y,
                                                   input logic             ci);
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             acc;
        logic             pp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & ci);
        end
        return {c[BLOCK-1], c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    logic adv;

    // Stage registers, index k = output of stage k. Operand skew registers
    // are shifted down so the next group to resolve always sits at bit 0.
    logic             vld_p [NGRP];
    logic [WIDTH-1:0] a_p   [NGRP];
    logic [WIDTH-1:0] b_p   [NGRP];
    logic [WIDTH-1:0] s_p   [NGRP];
    logic             c_p   [NGRP];

    // Stage inputs and combinational results.
    logic             v_s  [NGRP];
    logic [WIDTH-1:0] a_s  [NGRP];
    logic [WIDTH-1:0] b_s  [NGRP];
    logic [WIDTH-1:0] s_s  [NGRP];
    logic             c_s  [NGRP];
    logic [WIDTH-1:0] s_n  [NGRP];
    logic             co_n [NGRP];
    logic             cm_n [NGRP];

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    assign adv           = ~vld_p[NGRP-1] | bus.out_ready;
    assign bus.in_ready  = adv & ~rst;
    assign bus.out_valid = vld_p[NGRP-1];
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    always_comb begin
        logic [BLOCK+1:0] grp;
        int               km1;
        grp = '0;
        km1 = 0;
        for (int k = 0; k < NGRP; k++) begin
            km1 = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                // Operand conditioning at accept: subtract is a + ~b + 1.
                v_s[k] = bus.in_valid & bus.in_ready;
                a_s[k] = bus.a;
                b_s[k] = bus.sub ? ~bus.b : bus.b;
                c_s[k] = bus.cin ^ bus.sub;
                s_s[k] = '0;
            end else begin
                v_s[k] = vld_p[km1];
                a_s[k] = a_p[km1];
                b_s[k] = b_p[km1];
                c_s[k] = c_p[km1];
                s_s[k] = s_p[km1];
            end
            grp                     = cla_group(a_s[k][BLOCK-1:0], b_s[k][BLOCK-1:0], c_s[k]);
            s_n[k]                  = s_s[k];
            s_n[k][k*BLOCK +: BLOCK] = grp[BLOCK-1:0];
            co_n[k]                 = grp[BLOCK];
            cm_n[k]                 = grp[BLOCK+1];
        end
    end

    // Stage boundary: valid bits, the only pipeline state under reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NGRP; k++) vld_p[k] <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NGRP; k++) vld_p[k] <= v_s[k];
        end
    end

    // Stage boundary: operand skew, partial sum and group carry.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < NGRP; k++) begin
                a_p[k] <= a_s[k] >> BLOCK;
                b_p[k] <= b_s[k] >> BLOCK;
                s_p[k] <= s_n[k];
                c_p[k] <= co_n[k];
            end
        end
    end

    // Final stage boundary: result registers load only with a valid result,
    // so they hold through stalls and bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv && v_s[NGRP-1]) begin
            sum_q  <= s_n[NGRP-1];
            cout_q <= co_n[NGRP-1];
            ovf_q  <= cm_n[NGRP-1] ^ co_n[NGRP-1];
        end
    end
endmodule
